// File: rtl/vault_seq_if.sv
// rtl/vault_seq_if.sv - request, CAM/engine handshake and status bundle for vault_seq
interface vault_seq_if #(
   parameter int ADDR_W = 4
);
   logic              go;
   logic              op;
   logic              match;
   logic [ADDR_W-1:0] match_addr;
   logic              enc_done;
   logic              dec_done;
   logic [ADDR_W:0]   boot_count;
   logic              start_enc;
   logic              start_dec;
   logic              cam_write_en;
   logic              flash_write_en;
   logic              src_sel;
   logic              key_sel;
   logic              out_load;
   logic [ADDR_W-1:0] address_out;
   logic [ADDR_W:0]   entry_count;
   logic              busy;
   logic              done;
   logic [1:0]        status;

   modport master (
      output go, op, match, match_addr, enc_done, dec_done, boot_count,
      input  start_enc, start_dec, cam_write_en, flash_write_en, src_sel, key_sel,
             out_load, address_out, entry_count, busy, done, status
   );

   modport slave (
      input  go, op, match, match_addr, enc_done, dec_done, boot_count,
      output start_enc, start_dec, cam_write_en, flash_write_en, src_sel, key_sel,
             out_load, address_out, entry_count, busy, done, status
   );
endinterface

// File: rtl/vault_seq.sv
// rtl/vault_seq.sv - key vault sequencer: boot load, CAM lookup, dec/enc engines, store
module vault_seq #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16,
   parameter int TMO    = 255
) (
   input logic        clk,
   input logic        rst,
   vault_seq_if.slave bus
);
   localparam int              CW       = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [CW-1:0]   TMO_LAST = CW'(TMO - 1);
   localparam logic [1:0]      ST_OK = 2'd0, ST_NOT_FOUND = 2'd1, ST_FULL = 2'd2, ST_TIMEOUT = 2'd3;

   typedef enum logic [3:0] {
      BOOT_RD, BOOT_WR, IDLE, CHECK, DEC_START, DEC_WAIT, ENC_START, ENC_WAIT, STORE, RESP
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   idx_q, idx_d, idx_inc, lim_q, lim_eff, boot_clip;
   logic              lim_vld_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              tmo_hit;
   logic              op_q, op_d, add_q, add_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   ec_q, ec_d;
   logic [1:0]        status_q, status_d;
   logic              key_q, key_d;
   logic              start_enc_q, start_enc_d, start_dec_q, start_dec_d;
   logic              cam_we_q, cam_we_d, flash_we_q, flash_we_d;
   logic              src_q, src_d, out_load_q, out_load_d, busy_q, busy_d, done_q, done_d;

   // boot_count is captured on the first cycle after reset release and held until the next reset
   assign boot_clip = (bus.boot_count > DEPTH_C) ? DEPTH_C : bus.boot_count;
   assign lim_eff   = lim_vld_q ? lim_q : boot_clip;
   assign idx_inc   = idx_q + (ADDR_W + 1)'(1);
   assign tmo_hit   = (cnt_q == TMO_LAST);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= BOOT_RD;
      else      state_q <= state_d;
   end

   // next-state decode; done pulses outrank the timeout in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT_RD:   state_d = (idx_q == lim_eff) ? IDLE : BOOT_WR;
         BOOT_WR:   state_d = BOOT_RD;
         IDLE:      if (bus.go) state_d = CHECK;
         CHECK: begin
            if (bus.match)           state_d = DEC_START;
            else if (op_q)           state_d = RESP;
            else if (ec_q == DEPTH_C) state_d = RESP;
            else                     state_d = ENC_START;
         end
         DEC_START: state_d = DEC_WAIT;
         DEC_WAIT: begin
            if (bus.dec_done)  state_d = ENC_START;
            else if (tmo_hit)  state_d = RESP;
         end
         ENC_START: state_d = ENC_WAIT;
         ENC_WAIT: begin
            if (bus.enc_done)  state_d = add_q ? STORE : RESP;
            else if (tmo_hit)  state_d = RESP;
         end
         STORE:     state_d = RESP;
         RESP:      state_d = IDLE;
         default:   state_d = BOOT_RD;
      endcase
   end

   // next datapath values and next-cycle strobes, all keyed to the state being entered
   always_comb begin
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      add_d    = add_q;
      addr_d   = addr_q;
      ec_d     = ec_q;
      status_d = status_q;
      key_d    = key_q;
      case (state_q)
         BOOT_RD:   if (idx_q == lim_eff) ec_d = lim_eff;
         BOOT_WR: begin
            idx_d  = idx_inc;
            addr_d = idx_inc[ADDR_W-1:0];
         end
         IDLE: begin
            if (bus.go) begin
               op_d     = bus.op;
               add_d    = 1'b0;
               status_d = ST_OK;
            end
         end
         CHECK: begin
            if (bus.match)            addr_d   = bus.match_addr;
            else if (op_q)            status_d = ST_NOT_FOUND;
            else if (ec_q == DEPTH_C) status_d = ST_FULL;
            else begin
               addr_d = ec_q[ADDR_W-1:0];
               key_d  = 1'b0;
               add_d  = 1'b1;
            end
         end
         DEC_START, ENC_START: cnt_d = '0;
         DEC_WAIT: begin
            if (bus.dec_done)  key_d    = 1'b1;
            else if (tmo_hit)  status_d = ST_TIMEOUT;
            else               cnt_d    = cnt_q + CW'(1);
         end
         ENC_WAIT: begin
            if (bus.enc_done)  status_d = ST_OK;
            else if (tmo_hit)  status_d = ST_TIMEOUT;
            else               cnt_d    = cnt_q + CW'(1);
         end
         STORE: begin
            if (ec_q < DEPTH_C) ec_d = ec_q + (ADDR_W + 1)'(1);
            status_d = ST_OK;
         end
         default: ;
      endcase
      start_dec_d = (state_d == DEC_START);
      start_enc_d = (state_d == ENC_START);
      cam_we_d    = (state_d == BOOT_WR) || (state_d == STORE);
      flash_we_d  = (state_d == STORE);
      busy_d      = (state_d != BOOT_RD) && (state_d != BOOT_WR) && (state_d != IDLE);
      src_d       = busy_d;
      done_d      = (state_d == RESP);
      out_load_d  = (state_d == RESP) && (status_d == ST_OK);
   end

   // register datapath and every output so no input reaches a port combinationally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0; lim_q <= '0; lim_vld_q <= 1'b0; cnt_q <= '0;
         op_q <= 1'b0; add_q <= 1'b0; addr_q <= '0; ec_q <= '0;
         status_q <= ST_OK; key_q <= 1'b0;
         start_enc_q <= 1'b0; start_dec_q <= 1'b0; cam_we_q <= 1'b0; flash_we_q <= 1'b0;
         src_q <= 1'b0; out_load_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
      end else begin
         idx_q <= idx_d; lim_q <= lim_eff; lim_vld_q <= 1'b1; cnt_q <= cnt_d;
         op_q <= op_d; add_q <= add_d; addr_q <= addr_d; ec_q <= ec_d;
         status_q <= status_d; key_q <= key_d;
         start_enc_q <= start_enc_d; start_dec_q <= start_dec_d;
         cam_we_q <= cam_we_d; flash_we_q <= flash_we_d;
         src_q <= src_d; out_load_q <= out_load_d; busy_q <= busy_d; done_q <= done_d;
      end
   end

   assign bus.start_enc      = start_enc_q;
   assign bus.start_dec      = start_dec_q;
   assign bus.cam_write_en   = cam_we_q;
   assign bus.flash_write_en = flash_we_q;
   assign bus.src_sel        = src_q;
   assign bus.key_sel        = key_q;
   assign bus.out_load       = out_load_q;
   assign bus.address_out    = addr_q;
   assign bus.entry_count    = ec_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.status         = status_q;
endmodule

// File: tb/tb_vault_seq.sv
// tb/tb_vault_seq.sv - directed bench for vault_seq with a transaction-level expectation model
module tb_vault_seq;
   localparam int ADDR_W = 4, DEPTH = 16, TMO = 255;
   localparam logic [1:0] OK = 2'd0, NF = 2'd1, FULL = 2'd2, TOUT = 2'd3;

   typedef struct packed {
      logic start_enc, start_dec, cam_we, flash_we, src_sel, key_sel, out_load;
      logic [3:0] addr;
      logic [4:0] ec;
      logic busy, done;
      logic [1:0] status;
   } outv_t;
   typedef struct { outv_t v; string tag; } exp_t;
   typedef struct packed {
      logic go, op, match;
      logic [3:0] maddr;
      logic enc_done, dec_done;
   } inv_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vault_seq_if #(.ADDR_W(ADDR_W)) bus();
   vault_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TMO(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t exp_q[$];
   exp_t st_e[$];
   inv_t st_in[$];
   exp_t cur;
   inv_t z = '0;
   int n_chk = 0, n_pass = 0, flash_cnt = 0;
   int m_ec;
   logic [3:0] m_addr;
   logic m_key;
   logic [1:0] m_status;

   function automatic outv_t outs();
      outv_t o;
      o.start_enc = bus.start_enc; o.start_dec = bus.start_dec;
      o.cam_we = bus.cam_write_en; o.flash_we = bus.flash_write_en;
      o.src_sel = bus.src_sel; o.key_sel = bus.key_sel; o.out_load = bus.out_load;
      o.addr = bus.address_out; o.ec = bus.entry_count;
      o.busy = bus.busy; o.done = bus.done; o.status = bus.status;
      return o;
   endfunction

   function automatic void check(string name, logic [31:0] got, logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, want);
   endfunction

   function automatic outv_t base();
      outv_t v = '0;
      v.src_sel = 1'b1; v.busy = 1'b1; v.key_sel = m_key;
      v.addr = m_addr; v.ec = 5'(m_ec); v.status = OK;
      return v;
   endfunction

   function automatic void stage(string tag, outv_t v, inv_t iv);
      exp_t e;
      e.v = v;
      e.tag = $sformatf("%s.c%0d", tag, st_e.size());
      st_e.push_back(e);
      st_in.push_back(iv);
   endfunction

   function automatic bit wait_phase(string tag, int lat, bit is_dec, bit noise);
      int n;
      inv_t iv;
      n = (lat >= 0 && lat < TMO) ? lat + 1 : TMO;
      for (int j = 0; j < n; j++) begin
         iv = '0;
         if (is_dec) iv.dec_done = (j == lat);
         else        iv.enc_done = (j == lat);
         if (noise) begin
            iv.go = 1'b1; iv.op = 1'b1;
            if (is_dec) iv.enc_done = 1'b1;
            else        iv.dec_done = 1'b1;
         end
         stage(tag, base(), iv);
      end
      return (lat >= 0 && lat < TMO);
   endfunction

   function automatic void enc_part(string tag, int elat, bit add, bit noise);
      outv_t v;
      v = base(); v.start_enc = 1'b1; stage(tag, v, z);
      if (wait_phase(tag, elat, 1'b0, noise)) begin
         if (add) begin
            v = base(); v.cam_we = 1'b1; v.flash_we = 1'b1; stage(tag, v, z);
            m_ec++;
         end
         m_status = OK;
      end else m_status = TOUT;
   endfunction

   task automatic drive(inv_t iv);
      bus.go = iv.go; bus.op = iv.op; bus.match = iv.match; bus.match_addr = iv.maddr;
      bus.enc_done = iv.enc_done; bus.dec_done = iv.dec_done;
   endtask

   task automatic txn(string tag, bit op, bit hit, logic [3:0] maddr, int dlat, int elat,
                      bit noise, int cut);
      outv_t v;
      inv_t iv;
      int n;
      st_e.delete(); st_in.delete();
      m_status = OK;
      iv = z; iv.match = hit; iv.maddr = maddr;
      stage(tag, base(), iv);
      if (hit) begin
         m_addr = maddr;
         v = base(); v.start_dec = 1'b1; stage(tag, v, z);
         if (wait_phase(tag, dlat, 1'b1, noise)) begin
            m_key = 1'b1;
            enc_part(tag, elat, 1'b0, noise);
         end else m_status = TOUT;
      end else if (op) m_status = NF;
      else if (m_ec >= DEPTH) m_status = FULL;
      else begin
         m_addr = 4'(m_ec); m_key = 1'b0;
         enc_part(tag, elat, 1'b1, noise);
      end
      v = base(); v.done = 1'b1; v.status = m_status; v.out_load = (m_status == OK);
      stage(tag, v, z);
      v = base(); v.busy = 1'b0; v.src_sel = 1'b0; v.status = m_status;
      stage(tag, v, z);
      n = (cut > 0) ? cut : st_e.size();
      iv = z; iv.go = 1'b1; iv.op = op;
      drive(iv);
      for (int k = 0; k < n; k++) exp_q.push_back(st_e[k]);
      for (int k = 0; k < n; k++) begin
         @(negedge clk); #1;
         drive(st_in[k]);
      end
   endtask

   task automatic do_boot(string tag, int bc);
      int L, n;
      outv_t v;
      inv_t iv;
      rst = 1'b0; drive(z); bus.boot_count = 5'(bc);
      @(negedge clk);
      check({tag, ".reset_vec"}, 32'(outs()), 32'd0);
      @(negedge clk); #1;
      L = (bc > DEPTH) ? DEPTH : bc;
      st_e.delete(); st_in.delete();
      m_ec = 0; m_key = 1'b0; m_status = OK;
      for (int i = 0; i < L; i++) begin
         m_addr = 4'(i);
         v = base(); v.busy = 1'b0; v.src_sel = 1'b0; v.cam_we = 1'b1; stage(tag, v, z);
         m_addr = 4'(i + 1);
         v = base(); v.busy = 1'b0; v.src_sel = 1'b0; stage(tag, v, z);
      end
      m_ec = L; m_addr = 4'(L);
      v = base(); v.busy = 1'b0; v.src_sel = 1'b0; stage(tag, v, z);
      n = st_e.size();
      for (int k = 0; k < n; k++) exp_q.push_back(st_e[k]);
      rst = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk); #1;
         if (k == 0) bus.boot_count = 5'd7;
         iv = z; iv.go = (k < n - 1); iv.op = 1'b1;
         drive(iv);
      end
   endtask

   // compare DUT outputs against the staged expectation on every meaningful cycle
   initial forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         check(cur.tag, 32'(outs()), 32'(cur.v));
      end
   end

   // count flash write strobes across the whole run
   initial forever begin
      @(negedge clk);
      if (bus.flash_write_en === 1'b1) flash_cnt++;
   end

   // run bound
   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      drive(z); bus.boot_count = '0;
      do_boot("boot3", 3);
      check("boot3_ec", 32'(bus.entry_count), 32'd3);
      txn("fetch_hit", 1'b0, 1'b1, 4'd5, 2, 0, 1'b0, 0);
      check("hit_addr", 32'(bus.address_out), 32'd5);
      check("hit_key", 32'(bus.key_sel), 32'd1);
      txn("fetch_add", 1'b0, 1'b0, 4'd9, 0, 3, 1'b0, 0);
      check("add_ec", 32'(bus.entry_count), 32'd4);
      check("add_addr", 32'(bus.address_out), 32'd3);
      txn("query_miss", 1'b1, 1'b0, 4'd0, 0, 0, 1'b0, 0);
      check("query_miss_status", 32'(bus.status), 32'(NF));
      txn("query_hit", 1'b1, 1'b1, 4'd9, 0, 1, 1'b0, 0);
      txn("dec_tmo", 1'b0, 1'b1, 4'd2, -1, 0, 1'b1, 0);
      check("dec_tmo_status", 32'(bus.status), 32'(TOUT));
      txn("dec_edge", 1'b1, 1'b1, 4'd7, TMO - 1, 0, 1'b0, 0);
      check("dec_edge_status", 32'(bus.status), 32'(OK));
      txn("enc_tmo", 1'b0, 1'b1, 4'd1, 1, -1, 1'b1, 0);
      txn("add_tmo", 1'b0, 1'b0, 4'd0, 0, -1, 1'b0, 0);
      check("add_tmo_ec", 32'(bus.entry_count), 32'd4);
      for (int i = 0; i < 12; i++) txn("fill", 1'b0, 1'b0, 4'd0, 0, i % 3, 1'b0, 0);
      check("fill_ec", 32'(bus.entry_count), 32'd16);
      txn("full", 1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 0);
      check("full_status", 32'(bus.status), 32'(FULL));
      txn("full_query", 1'b1, 1'b0, 4'd0, 0, 0, 1'b0, 0);
      txn("full_hit", 1'b0, 1'b1, 4'd15, 1, 1, 1'b0, 0);
      do_boot("boot20", 20);
      check("boot20_ec", 32'(bus.entry_count), 32'd16);
      do_boot("boot0", 0);
      check("boot0_ec", 32'(bus.entry_count), 32'd0);
      txn("add0", 1'b0, 1'b0, 4'd0, 0, 0, 1'b0, 0);
      txn("abort", 1'b0, 1'b0, 4'd0, 0, -1, 1'b0, 4);
      do_boot("boot5", 5);
      check("boot5_ec", 32'(bus.entry_count), 32'd5);
      check("abort_flash", 32'(flash_cnt), 32'd14);
      txn("add5", 1'b0, 1'b0, 4'd0, 0, 2, 1'b0, 0);
      check("add5_addr", 32'(bus.address_out), 32'd5);
      check("add5_ec", 32'(bus.entry_count), 32'd6);
      check("flash_total", 32'(flash_cnt), 32'd15);
      check("exp_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vault_seq.md
VAULT_SEQ -- requirements
Module: vault_seq

Interface
REQ-001 Parameter ADDR_W, default 4, width of the entry address.
REQ-002 Parameter DEPTH, default 16, number of CAM/flash entries (≤ 2**ADDR_W).
REQ-003 Parameter TMO, default 255, maximum wait cycles for an enc/dec engine.
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, reset; asynchronous, active-low.
REQ-006 Port go, input, 1, request strobe; accepted only in IDLE.
REQ-007 Port op, input, 1, operation: 0 = FETCH (lookup, add if absent), 1 = QUERY (lookup only).
REQ-008 Port match, input, 1, CAM hit for the current access key.
REQ-009 Port match_addr, input, ADDR_W, CAM hit address.
REQ-010 Port enc_done / dec_done, input, 1 each, engine completion pulses.
REQ-011 Port boot_count, input, ADDR_W+1, number of valid flash entries; sampled once at reset release.
REQ-012 Port start_enc / start_dec, output, 1 each, one-cycle engine start pulses.
REQ-013 Port cam_write_en / flash_write_en, output, 1 each, one-cycle write strobes.
REQ-014 Port src_sel, output, 1: 0 = flash data, 1 = access key, on the CAM input.
REQ-015 Port key_sel, output, 1: 0 = local key, 1 = master key, to the encryptor.
REQ-016 Port out_load, output, 1, loads the output register.
REQ-017 Port address_out, output, ADDR_W, shared CAM/flash address.
REQ-018 Port entry_count, output, ADDR_W+1, number of valid entries.
REQ-019 Port busy, output, 1; port done, output, 1; port status, output, 2 (0 = OK, 1 = NOT_FOUND, 2 = FULL, 3 = TIMEOUT).

Function
REQ-020 States SHALL be BOOT_RD, BOOT_WR, IDLE, CHECK, DEC_START, DEC_WAIT, ENC_START, ENC_WAIT, STORE, RESP.
REQ-021 Boot: a load index runs from 0 to min(boot_count, DEPTH)-1.
 - BOOT_RD drives address_out = index with src_sel = 0.
 - BOOT_WR pulses cam_write_en, then increments the index.
 - When the index reaches the limit, the FSM enters IDLE with entry_count = limit.
REQ-022 boot_count > DEPTH SHALL be clipped to DEPTH; boot_count = 0 SHALL go directly to IDLE one cycle after reset release.
REQ-023 IDLE: busy = 0. go = 1 latches op, sets busy = 1, drives src_sel = 1, and moves to CHECK. A go seen in any other state SHALL be ignored.
REQ-024 CHECK: when match = 1, latch match_addr to address_out and go to DEC_START.
REQ-025 CHECK: when match = 0 and op = 1, go to RESP with status NOT_FOUND.
REQ-026 CHECK: when match = 0, op = 0 and entry_count = DEPTH, go to RESP with status FULL; no write strobes are issued.
REQ-027 CHECK: when match = 0, op = 0 and not full, set address_out = entry_count[ADDR_W-1:0] and go to ENC_START with key_sel = 0.
REQ-028 DEC_START: pulse start_dec for one cycle, then go to DEC_WAIT. On dec_done, go to ENC_START with key_sel = 1.
REQ-029 ENC_START: pulse start_enc for one cycle, then go to ENC_WAIT. On enc_done, go to STORE if a new entry is being added, otherwise to RESP with status OK.
REQ-030 STORE: pulse cam_write_en and flash_write_en together for one cycle, increment entry_count, and go to RESP with status OK.
REQ-031 DEC_WAIT and ENC_WAIT SHALL count cycles. If the count reaches TMO without a done pulse, go to RESP with status TIMEOUT and perform no write. A done pulse in the same cycle as the timeout SHALL win.
REQ-032 RESP: pulse out_load only when status = OK. Pulse done for exactly one cycle, hold status until the next accepted go, then return to IDLE.
REQ-033 enc_done and dec_done pulses arriving outside their wait state SHALL be ignored.
REQ-034 entry_count SHALL never exceed DEPTH and never wrap.
REQ-035 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-036 rst = 0 SHALL immediately force state BOOT_RD, index 0, entry_count 0, status 0, address_out 0, and every strobe, select, busy and done to 0.
REQ-037 Reset asserted mid-operation SHALL abort without completing any pending write. After release, the boot replays from the new boot_count.

Verification
REQ-038 boot_count = 3 -> cam_write_en pulses at addresses 0, 1, 2; IDLE reached with entry_count = 3.
REQ-039 FETCH, match = 1, match_addr = 5 -> start_dec, then start_enc with key_sel = 1; no write strobes; done with status OK; out_load = 1.
REQ-040 FETCH, match = 0, entry_count = 3 -> start_enc with key_sel = 0; cam and flash write at address 3; entry_count = 4; status OK.
REQ-041 FETCH, match = 0, entry_count = 16 (DEPTH 16) -> status FULL; no start pulses; no write strobes.
REQ-042 QUERY, match = 0 -> status NOT_FOUND; dec_done withheld on a hit -> status TIMEOUT after 255 cycles; next go accepted.
REQ-043 rst low during ENC_WAIT of an add -> no flash_write_en; re-boot with entry_count = boot_count.
